// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//
// Parametrised vending controller with per-item stock counters, coin refusal
// on credit overflow and a change-return sequencer that pays out one coin per
// cycle, largest denomination first.
//
// Optional feature macro: VM_AUTO_RETURN_EN
//   When defined, credit left idle for TIMEOUT_CYCLES cycles is returned
//   automatically, exactly as if i_trigger_return had been pulsed.
//   When undefined, credit is held indefinitely.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   reset             asynchronous, active-high reset
//   i_input_coin      one-hot coin insertion, valid for one cycle
//   i_select_item     one-hot item selection
//   i_trigger_return  change-return request
//   i_restock         per-item restock pulse, adds 1 to that item's stock
//   o_available_item  combinational: item purchasable right now
//   o_output_item     registered one-cycle vend pulse
//   o_return_coin     registered one-hot change coin, one per cycle
//   o_reject_coin     registered echo of a refused coin
//   o_current_total   registered credit
//   o_busy            high while change is being returned
//   o_sold_out        combinational: stock of item i is zero
//   o_state           debug view of the FSM state (0 = S_IDLE, 1 = S_RETURN)
//
// Input semantics: every input is a single-cycle pulse sampled on the rising
// edge; there is no back-pressure. Anything the controller cannot take in a
// given cycle is either echoed on o_reject_coin (coins) or dropped (selects,
// triggers).
// -----------------------------------------------------------------------------
module vending_machine_param #(
    parameter int                      NUM_ITEMS      = 4,
    parameter int                      NUM_COINS      = 3,
    parameter int                      TOTAL_BITS     = 16,
    parameter int                      MAX_TOTAL      = 5000,
    parameter logic [NUM_ITEMS*16-1:0] ITEM_PRICES    = {16'd2000, 16'd1000, 16'd500, 16'd400},
    parameter logic [NUM_COINS*16-1:0] COIN_VALUES    = {16'd1000, 16'd500, 16'd100},
    parameter int                      STOCK_BITS     = 4,
    parameter int                      INIT_STOCK     = 3,
    parameter int                      TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic [NUM_ITEMS-1:0]  i_restock,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [NUM_COINS-1:0]  o_reject_coin,
    output logic [TOTAL_BITS-1:0] o_current_total,
    output logic                  o_busy,
    output logic [NUM_ITEMS-1:0]  o_sold_out,
    output logic [0:0]            o_state
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RETURN = 1'b1;

    localparam logic [TOTAL_BITS:0]   MAX_SUM    = (TOTAL_BITS + 1)'(MAX_TOTAL);
    localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);
    localparam logic [STOCK_BITS-1:0] STOCK_MAX  = '1;

    // Elaboration-time parameter sanity checks.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("vending_machine_param: TIMEOUT_CYCLES must be at least 1");
        end
        if (MAX_TOTAL >= (2 ** TOTAL_BITS)) begin : g_bad_max_total
            $error("vending_machine_param: MAX_TOTAL does not fit in TOTAL_BITS");
        end
    endgenerate

    function automatic logic [TOTAL_BITS-1:0] price_of(input int idx);
        return TOTAL_BITS'(ITEM_PRICES[idx*16 +: 16]);
    endfunction

    function automatic logic [TOTAL_BITS-1:0] coin_value_of(input int idx);
        return TOTAL_BITS'(COIN_VALUES[idx*16 +: 16]);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [STOCK_BITS-1:0] stock_q [NUM_ITEMS];

    logic [NUM_ITEMS-1:0]  out_item_d;
    logic [NUM_COINS-1:0]  ret_coin_d;
    logic [NUM_COINS-1:0]  rej_coin_d;

    logic                  timeout_hit;

    // -------------------------------------------------------------------------
    // Per-item status, derived only from registered state
    // -------------------------------------------------------------------------
    logic [NUM_ITEMS-1:0] avail_vec;
    logic [NUM_ITEMS-1:0] sold_vec;

    always_comb begin
        avail_vec = '0;
        sold_vec  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_vec[i]  = (stock_q[i] == '0);
            avail_vec[i] = (state_q == S_IDLE) && (total_q >= price_of(i)) && (stock_q[i] != '0);
        end
    end

    assign o_available_item = avail_vec;
    assign o_sold_out       = sold_vec;
    assign o_current_total  = total_q;
    assign o_busy           = (state_q == S_RETURN);
    assign o_state          = state_q;

    // -------------------------------------------------------------------------
    // Input decode
    // -------------------------------------------------------------------------
    logic                  coin_valid;
    logic                  sel_valid;
    logic [TOTAL_BITS-1:0] coin_val;
    logic [NUM_ITEMS-1:0]  vend_cand;
    logic [TOTAL_BITS-1:0] vend_price;

    assign coin_valid = $onehot(i_input_coin);
    assign sel_valid  = $onehot(i_select_item);

    // Eligibility uses the registered (pre-coin) total, so a coin arriving in
    // the same cycle never enables a purchase by itself.
    assign vend_cand  = sel_valid ? (i_select_item & avail_vec) : '0;

    always_comb begin
        coin_val = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (i_input_coin[j]) begin
                coin_val = coin_val | coin_value_of(j);
            end
        end
    end

    always_comb begin
        vend_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (vend_cand[i]) begin
                vend_price = vend_price | price_of(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Change selection: denominations ascend with index, so the last coin that
    // fits while scanning upwards is the largest one.
    // -------------------------------------------------------------------------
    logic                  ret_found;
    logic [NUM_COINS-1:0]  ret_vec;
    logic [TOTAL_BITS-1:0] ret_val;

    always_comb begin
        ret_found = 1'b0;
        ret_vec   = '0;
        ret_val   = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (coin_value_of(j) <= total_q) begin
                ret_found  = 1'b1;
                ret_vec    = '0;
                ret_vec[j] = 1'b1;
                ret_val    = coin_value_of(j);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [TOTAL_BITS-1:0] after_vend;
    logic [TOTAL_BITS:0]   coin_sum;

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        out_item_d = '0;
        ret_coin_d = '0;
        rej_coin_d = '0;
        after_vend = total_q;
        coin_sum   = '0;
        case (state_q)
            S_IDLE: begin
                if ((i_trigger_return || timeout_hit) && (total_q != '0)) begin
                    // Return takes priority; this cycle's coin is handed back.
                    state_d    = S_RETURN;
                    rej_coin_d = i_input_coin;
                end else begin
                    out_item_d = vend_cand;
                    after_vend = total_q - vend_price;
                    total_d    = after_vend;
                    if (coin_valid) begin
                        // One extra bit so the overflow test cannot wrap.
                        coin_sum = {1'b0, after_vend} + {1'b0, coin_val};
                        if (coin_sum > MAX_SUM) begin
                            rej_coin_d = i_input_coin;
                        end else begin
                            total_d = coin_sum[TOTAL_BITS-1:0];
                        end
                    end else begin
                        // Zero or multi-hot pattern: echo whatever arrived.
                        rej_coin_d = i_input_coin;
                    end
                end
            end
            default: begin
                rej_coin_d = i_input_coin;
                if (ret_found) begin
                    ret_coin_d = ret_vec;
                    total_d    = total_q - ret_val;
                    if (total_q == ret_val) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    // Remainder below the smallest coin cannot be paid out.
                    total_d = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            total_q       <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_reject_coin <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_INIT;
            end
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            o_output_item <= out_item_d;
            o_return_coin <= ret_coin_d;
            o_reject_coin <= rej_coin_d;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                // A restock and a vend of the same item cancel out.
                if (i_restock[i] && out_item_d[i]) begin
                    stock_q[i] <= stock_q[i];
                end else if (out_item_d[i]) begin
                    stock_q[i] <= stock_q[i] - 1'b1;
                end else if (i_restock[i] && (stock_q[i] != STOCK_MAX)) begin
                    stock_q[i] <= stock_q[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Idle auto-return
    // -------------------------------------------------------------------------
`ifdef VM_AUTO_RETURN_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q;
    logic              activity;

    // An accepted coin is a valid coin in S_IDLE that was not echoed back.
    assign activity    = (state_q == S_IDLE) &&
                         ((out_item_d != '0) || (coin_valid && (rej_coin_d == '0)));
    assign timeout_hit = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if ((state_q != S_IDLE) || (total_q == '0) || activity ||
                     timeout_hit || i_trigger_return) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_param
//
// Bench for vending_machine_param. A transaction-level model tracks credit,
// stock and the pending list of change coins; a compare process checks every
// DUT output against it on each falling edge. Directed scenarios add literal
// expectations, then a randomized phase exercises the controller at length.
// -----------------------------------------------------------------------------
module tb_vending_machine_param;

    localparam int NI    = 4;
    localparam int NC    = 3;
    localparam int MAXT  = 5000;
    localparam int SMAX  = 15;
    localparam int INITS = 3;
    localparam int PRICE [NI] = '{400, 500, 1000, 2000};
    localparam int VAL   [NC] = '{100, 500, 1000};

    localparam logic [2:0] C100  = 3'b001;
    localparam logic [2:0] C500  = 3'b010;
    localparam logic [2:0] C1000 = 3'b100;

    // ---------------------------------------------------------------- clock/reset
    logic          clk;
    logic          reset;
    logic [NC-1:0] i_input_coin;
    logic [NI-1:0] i_select_item;
    logic          i_trigger_return;
    logic [NI-1:0] i_restock;
    logic [NI-1:0] o_available_item;
    logic [NI-1:0] o_output_item;
    logic [NC-1:0] o_return_coin;
    logic [NC-1:0] o_reject_coin;
    logic [15:0]   o_current_total;
    logic          o_busy;
    logic [NI-1:0] o_sold_out;
    logic [0:0]    o_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vending_machine_param dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_restock        (i_restock),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_reject_coin    (o_reject_coin),
        .o_current_total  (o_current_total),
        .o_busy           (o_busy),
        .o_sold_out       (o_sold_out),
        .o_state          (o_state)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int m_total;
    int m_stock [NI];
    int m_ret_q [$];
    bit m_in_ret;
    int e_item;
    int e_ret;
    int e_rej;

    function automatic int onehot_idx(input int v, input int w);
        int n   = 0;
        int idx = -1;
        for (int b = 0; b < w; b++) begin
            if (v[b]) begin
                n++;
                idx = b;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic model_reset();
        m_total = 0;
        for (int i = 0; i < NI; i++) m_stock[i] = INITS;
        m_ret_q.delete();
        m_in_ret = 1'b0;
        e_item = 0;
        e_ret  = 0;
        e_rej  = 0;
    endtask

    task automatic model_step(input int coin, input int sel, input bit trig, input int rest);
        int vend = -1;
        int c;
        int s;
        int t;
        e_item = 0;
        e_ret  = 0;
        e_rej  = 0;
        if (m_in_ret) begin
            e_rej = coin;
            if (m_ret_q.size() == 0) begin
                m_total  = 0;
                m_in_ret = 1'b0;
            end else begin
                c = m_ret_q.pop_front();
                e_ret = 1 << c;
                m_total -= VAL[c];
                if (m_ret_q.size() == 0) m_in_ret = 1'b0;
            end
        end else if (trig && m_total > 0) begin
            // Plan the whole payout now: greedy, largest coin first.
            t = m_total;
            while (t >= VAL[0]) begin
                for (int j = NC - 1; j >= 0; j--) begin
                    if (VAL[j] <= t) begin
                        m_ret_q.push_back(j);
                        t -= VAL[j];
                        break;
                    end
                end
            end
            m_in_ret = 1'b1;
            e_rej = coin;
        end else begin
            s = onehot_idx(sel, NI);
            c = onehot_idx(coin, NC);
            if (s >= 0 && m_total >= PRICE[s] && m_stock[s] > 0) vend = s;
            t = m_total - ((vend >= 0) ? PRICE[vend] : 0);
            if (c < 0) e_rej = coin;
            else if (t + VAL[c] > MAXT) e_rej = coin;
            else t += VAL[c];
            m_total = t;
            if (vend >= 0) e_item = 1 << vend;
        end
        for (int i = 0; i < NI; i++) begin
            if (rest[i] && vend == i) begin
                // cancels out
            end else if (vend == i) begin
                m_stock[i]--;
            end else if (rest[i] && m_stock[i] < SMAX) begin
                m_stock[i]++;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step(int'(i_input_coin), int'(i_select_item), i_trigger_return, int'(i_restock));
    end

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin : compare
        int ea;
        int es;
        if (chk_en && !reset) begin
            ea = 0;
            es = 0;
            for (int i = 0; i < NI; i++) begin
                if (m_stock[i] == 0) es |= (1 << i);
                if (!m_in_ret && m_total >= PRICE[i] && m_stock[i] != 0) ea |= (1 << i);
            end
            check("total",     int'(o_current_total),  m_total);
            check("item",      int'(o_output_item),    e_item);
            check("ret_coin",  int'(o_return_coin),    e_ret);
            check("rej_coin",  int'(o_reject_coin),    e_rej);
            check("busy",      int'(o_busy),           int'(m_in_ret));
            check("state",     int'(o_state),          int'(m_in_ret));
            check("available", int'(o_available_item), ea);
            check("sold_out",  int'(o_sold_out),       es);
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic clear_inputs();
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        i_restock        = '0;
    endtask

    // Present one cycle of inputs; returns at the falling edge after the
    // capturing rising edge, with inputs cleared.
    task automatic apply(input logic [2:0] coin, input logic [3:0] sel,
                         input logic trig, input logic [3:0] rest);
        @(negedge clk);
        i_input_coin     = coin;
        i_select_item    = sel;
        i_trigger_return = trig;
        i_restock        = rest;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int r;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_total",   int'(o_current_total),  0);
        check("rst_busy",    int'(o_busy),           0);
        check("rst_sold",    int'(o_sold_out),       0);
        check("rst_avail",   int'(o_available_item), 0);
        check("rst_ret",     int'(o_return_coin),    0);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Buy item0 for 400 out of 500.
        apply(C500, 4'b0000, 1'b0, 4'b0000);
        check("buy_credit", int'(o_current_total), 500);
        apply(3'b000, 4'b0001, 1'b0, 4'b0000);
        check("buy_item",   int'(o_output_item),   1);
        check("buy_change", int'(o_current_total), 100);
        @(negedge clk);
        check("buy_pulse",  int'(o_output_item),   0);

        // 1600 returned as 1000, 500, 100.
        apply(C1000, 4'b0000, 1'b0, 4'b0000);
        apply(C500,  4'b0000, 1'b0, 4'b0000);
        check("ret_start",  int'(o_current_total), 1600);
        apply(3'b000, 4'b0000, 1'b1, 4'b0000);
        check("ret_busy0",  int'(o_busy),          1);
        check("ret_none",   int'(o_return_coin),   0);
        @(negedge clk);
        check("ret_c1",     int'(o_return_coin),   4);
        check("ret_t1",     int'(o_current_total), 600);
        @(negedge clk);
        check("ret_c2",     int'(o_return_coin),   2);
        check("ret_t2",     int'(o_current_total), 100);
        check("ret_busy2",  int'(o_busy),          1);
        @(negedge clk);
        check("ret_c3",     int'(o_return_coin),   1);
        check("ret_t3",     int'(o_current_total), 0);
        check("ret_idle",   int'(o_busy),          0);

        // Sell out item0, then restock it.
        do_reset();
        apply(C1000, 4'b0000, 1'b0, 4'b0000);
        apply(C1000, 4'b0000, 1'b0, 4'b0000);
        repeat (3) apply(3'b000, 4'b0001, 1'b0, 4'b0000);
        check("so_total",   int'(o_current_total), 800);
        check("so_sold",    int'(o_sold_out),      1);
        check("so_avail0",  int'(o_available_item[0]), 0);
        apply(3'b000, 4'b0001, 1'b0, 4'b0000);
        check("so_novend",  int'(o_output_item),   0);
        check("so_keep",    int'(o_current_total), 800);
        apply(3'b000, 4'b0000, 1'b0, 4'b0001);
        check("rs_avail0",  int'(o_available_item[0]), 1);
        check("rs_sold",    int'(o_sold_out),      0);

        // Overflow refusal at the credit ceiling.
        do_reset();
        repeat (4) apply(C1000, 4'b0000, 1'b0, 4'b0000);
        apply(C500, 4'b0000, 1'b0, 4'b0000);
        check("ov_start",   int'(o_current_total), 4500);
        apply(C1000, 4'b0000, 1'b0, 4'b0000);
        check("ov_reject",  int'(o_reject_coin),   4);
        check("ov_keep",    int'(o_current_total), 4500);
        apply(C500, 4'b0000, 1'b0, 4'b0000);
        check("ov_max",     int'(o_current_total), 5000);
        check("ov_norej",   int'(o_reject_coin),   0);

        // Coin and select together use the pre-coin total.
        do_reset();
        apply(C500, 4'b0000, 1'b0, 4'b0000);
        apply(C500, 4'b0010, 1'b0, 4'b0000);
        check("cs_item",    int'(o_output_item),   2);
        check("cs_total",   int'(o_current_total), 500);
        apply(3'b000, 4'b0000, 1'b1, 4'b0000);
        @(negedge clk);
        check("cs_drain",   int'(o_current_total), 0);
        apply(C500, 4'b0010, 1'b0, 4'b0000);
        check("cs_noitem",  int'(o_output_item),   0);
        check("cs_total0",  int'(o_current_total), 500);

        // Reset in the middle of a payout.
        apply(C1000, 4'b0000, 1'b0, 4'b0000);
        apply(3'b000, 4'b0000, 1'b1, 4'b0000);
        @(negedge clk);
        check("mr_c1",      int'(o_return_coin),   4);
        #2;
        reset = 1'b1;
        #1;
        check("mr_ret",     int'(o_return_coin),   0);
        check("mr_total",   int'(o_current_total), 0);
        check("mr_busy",    int'(o_busy),          0);
        check("mr_state",   int'(o_state),         0);
        check("mr_sold",    int'(o_sold_out),      0);
        @(negedge clk);
        reset = 1'b0;

        // Invalid coin pattern, multi-hot select, trigger with no credit.
        apply(3'b011, 4'b0000, 1'b0, 4'b0000);
        check("inv_rej",    int'(o_reject_coin),   3);
        check("inv_total",  int'(o_current_total), 0);
        apply(3'b000, 4'b0000, 1'b1, 4'b0000);
        check("trig0_busy", int'(o_busy),          0);
        apply(C1000, 4'b0011, 1'b0, 4'b0000);
        check("multi_sel",  int'(o_output_item),   0);

        // Randomized phase.
        repeat (3000) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 30)      i_input_coin = 3'(1 << $urandom_range(0, NC - 1));
            else if (r < 36) i_input_coin = 3'($urandom_range(0, 7));
            else             i_input_coin = '0;
            r = $urandom_range(0, 99);
            if (r < 20)      i_select_item = 4'(1 << $urandom_range(0, NI - 1));
            else if (r < 24) i_select_item = 4'($urandom_range(0, 15));
            else             i_select_item = '0;
            i_trigger_return = ($urandom_range(0, 99) < 4);
            for (int i = 0; i < NI; i++) i_restock[i] = ($urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        clear_inputs();
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
